// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr
// Purpose  : N-channel streaming multiplexer with valid/ready handshakes on
//            every input and on the output. A channel is chosen by
//            round-robin or by an external select, then held until its
//            packet ends. The output is a single register stage.
// Ports    : clk_i, rst_ni                - clock, async active-low reset
//            in_data_i/in_valid_i/in_last_i - N input streams (ch k at k*W)
//            in_ready_o                   - per-channel ready (one-hot or 0)
//            mode_i, sel_i                - 0 = round-robin, 1 = fixed select
//            out_data_o/out_valid_o/out_last_o/out_chan_o, out_ready_i
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N*W-1:0] in_data_i,
  input  logic [N-1:0]   in_valid_i,
  input  logic [N-1:0]   in_last_i,
  output logic [N-1:0]   in_ready_o,
  input  logic           mode_i,
  input  logic [CW-1:0]  sel_i,
  output logic [W-1:0]   out_data_o,
  output logic           out_valid_o,
  output logic           out_last_o,
  output logic [CW-1:0]  out_chan_o,
  input  logic           out_ready_i
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] grant_q, grant_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [CW-1:0] out_chan_q, out_chan_d;

  logic          cand_found;
  logic [CW-1:0] cand_idx;
  logic [CW-1:0] act_chan;
  logic          act_ok;
  logic          space;
  logic          xfer;

  // Candidate selection while idle. The round-robin scan runs from the
  // farthest offset down to offset 0 so the last hit is the nearest to ptr.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    if (mode_i) begin
      // sel values >= N never match any k, so they select nothing.
      for (int k = 0; k < N; k++) begin
        if ((int'(sel_i) == k) && in_valid_i[k]) begin
          cand_found = 1'b1;
          cand_idx   = CW'(k);
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid_i[(int'(ptr_q) + i) % N]) begin
          cand_found = 1'b1;
          cand_idx   = CW'((int'(ptr_q) + i) % N);
        end
      end
    end
  end

  assign space    = !out_valid_q || out_ready_i;
  assign act_chan = (state_q == ST_LOCKED) ? grant_q : cand_idx;
  assign act_ok   = (state_q == ST_LOCKED) || cand_found;

  // Ready is forced low while reset is asserted, independent of state.
  for (genvar k = 0; k < N; k++) begin : g_ready
    assign in_ready_o[k] = rst_ni && act_ok && space && (act_chan == CW'(k));
  end

  assign xfer = |(in_valid_i & in_ready_o);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_chan_d  = out_chan_q;
    if (xfer) begin
      out_data_d  = in_data_i[int'(act_chan)*W +: W];
      out_valid_d = 1'b1;
      out_last_d  = in_last_i[act_chan];
      out_chan_d  = act_chan;
      if (in_last_i[act_chan]) begin
        state_d = ST_IDLE;
        ptr_d   = (int'(act_chan) == N - 1) ? '0 : act_chan + 1'b1;
      end else begin
        state_d = ST_LOCKED;
        grant_d = act_chan;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_chan_o  = out_chan_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_rr
// Purpose  : Bench for stream_mux_rr (N=4 main instance, N=3 side instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  in_data = '0;
  logic [3:0]   in_valid = '0;
  logic [3:0]   in_last = '0;
  logic [3:0]   in_ready;
  logic         mode = 1'b0;
  logic [1:0]   sel = '0;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_last;
  logic [1:0]   out_chan;
  logic         out_ready = 1'b0;

  // Three-channel instance: select value 3 is out of range.
  logic [23:0]  in_data3 = 24'h332211;
  logic [2:0]   in_valid3 = 3'b111;
  logic [2:0]   in_last3 = 3'b111;
  logic [2:0]   in_ready3;
  logic [7:0]   out_data3;
  logic         out_valid3;
  logic         out_last3;
  logic [1:0]   out_chan3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N(4), .W(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last),
    .in_ready_o(in_ready), .mode_i(mode), .sel_i(sel),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_last_o(out_last),
    .out_chan_o(out_chan), .out_ready_i(out_ready)
  );

  stream_mux_rr #(.N(3), .W(8)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_data_i(in_data3), .in_valid_i(in_valid3), .in_last_i(in_last3),
    .in_ready_o(in_ready3), .mode_i(1'b1), .sel_i(2'd3),
    .out_data_o(out_data3), .out_valid_o(out_valid3), .out_last_o(out_last3),
    .out_chan_o(out_chan3), .out_ready_i(1'b1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [7:0] d, input logic l);
    in_data[k*8 +: 8] = d;
    in_last[k] = l;
  endtask

  // Behavioural model: which channel owns the output, where the round-robin
  // search starts, and what the output register must hold.
  int         m_owner = -1;
  int         m_ptr = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = '0;
  logic       m_last = 1'b0;
  int         m_chan = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_owner = -1; m_ptr = 0; m_valid = 1'b0; m_data = '0; m_last = 1'b0; m_chan = 0;
        chk("m_ready_rst", 32'(in_ready), 32'h0);
        chk("m_valid_rst", 32'(out_valid), 32'h0);
        chk("m_data_rst", 32'(out_data), 32'h0);
        chk("m_chan_rst", 32'(out_chan), 32'h0);
      end else begin
        int  g;
        bit  room;
        logic [3:0] exp_rdy;
        g = -1;
        if (m_owner >= 0) g = m_owner;
        else if (mode) begin
          if (int'(sel) < N && in_valid[sel]) g = int'(sel);
        end else begin
          for (int i = 0; i < N && g < 0; i++)
            if (in_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        end
        room = !m_valid || out_ready;
        exp_rdy = (g >= 0 && room) ? 4'(1 << g) : 4'h0;
        chk("m_ready", 32'(in_ready), 32'(exp_rdy));
        chk("m_valid", 32'(out_valid), 32'(m_valid));
        chk("m_data", 32'(out_data), 32'(m_data));
        chk("m_last", 32'(out_last), 32'(m_last));
        chk("m_chan", 32'(out_chan), 32'(m_chan));
        if (exp_rdy != 0 && in_valid[g]) begin
          m_valid = 1'b1;
          m_data  = in_data[g*8 +: 8];
          m_last  = in_last[g];
          m_chan  = g;
          if (in_last[g]) begin
            m_owner = -1;
            m_ptr   = (g + 1) % N;
          end else begin
            m_owner = g;
          end
        end else if (out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Out-of-range select on the three-channel instance.
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("n3_ready", 32'(in_ready3), 32'h0);
      chk("n3_valid", 32'(out_valid3), 32'h0);
    end

    // Round-robin over single-beat packets.
    @(posedge clk); #1;
    mode = 1'b0; out_ready = 1'b1; in_valid = 4'hF;
    for (int k = 0; k < 4; k++) set_ch(k, 8'(8'h10 + k), 1'b1);
    @(negedge clk);
    chk("t1_ready0", 32'(in_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t1_chan", 32'(out_chan), 32'(i % 4));
      chk("t1_data", 32'(out_data), 32'(8'h10 + (i % 4)));
    end
    @(posedge clk); #1;

    // Three-beat packet on channel 2 with a 3-cycle stall.
    in_valid = 4'b0111;
    set_ch(2, 8'hA1, 1'b0);
    @(negedge clk);
    chk("t2_ready_a1", 32'(in_ready), 32'h4);
    @(posedge clk); #1; set_ch(2, 8'hA2, 1'b0);
    @(negedge clk);
    chk("t2_data_a1", 32'(out_data), 32'hA1);
    chk("t2_chan_a1", 32'(out_chan), 32'h2);
    chk("t2_ready_a2", 32'(in_ready), 32'h4);
    @(posedge clk); #1; set_ch(2, 8'hA3, 1'b1); out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("t2_stall_data", 32'(out_data), 32'hA2);
      chk("t2_stall_ready", 32'(in_ready), 32'h0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    chk("t2_ready_a3", 32'(in_ready), 32'h4);
    @(posedge clk); #1; in_valid[2] = 1'b0;
    @(negedge clk);
    chk("t2_data_a3", 32'(out_data), 32'hA3);
    chk("t2_last_a3", 32'(out_last), 32'h1);
    chk("t2_ready_next", 32'(in_ready), 32'h1);
    @(posedge clk); #1; in_valid = 4'h0;
    @(negedge clk);
    chk("t2_chan_next", 32'(out_chan), 32'h0);

    // Fixed select; select change mid-packet is ignored until the end.
    @(posedge clk); #1;
    mode = 1'b1; sel = 2'd1; in_valid = 4'b0011;
    set_ch(0, 8'h10, 1'b1); set_ch(1, 8'hB1, 1'b0);
    @(negedge clk);
    chk("t3_ready_b1", 32'(in_ready), 32'h2);
    @(posedge clk); #1;
    sel = 2'd3; in_valid = 4'b1011; set_ch(1, 8'hB2, 1'b1); set_ch(3, 8'hC3, 1'b1);
    @(negedge clk);
    chk("t3_data_b1", 32'(out_data), 32'hB1);
    chk("t3_ready_b2", 32'(in_ready), 32'h2);
    @(posedge clk);
    @(negedge clk);
    chk("t3_data_b2", 32'(out_data), 32'hB2);
    chk("t3_ready_c3", 32'(in_ready), 32'h8);
    @(posedge clk); #1; in_valid = 4'h0;
    @(negedge clk);
    chk("t3_chan_c3", 32'(out_chan), 32'h3);

    // Reset during the second beat of a packet.
    @(posedge clk); #1;
    mode = 1'b0; in_valid = 4'b0100; set_ch(2, 8'hD1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0; set_ch(2, 8'hD2, 1'b0); set_ch(0, 8'hE0, 1'b1); in_valid = 4'b0101;
    @(negedge clk);
    chk("t4_rst_valid", 32'(out_valid), 32'h0);
    chk("t4_rst_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("t4_ready_ch0", 32'(in_ready), 32'h1);
    @(posedge clk); #1; in_valid = 4'h0;
    @(negedge clk);
    chk("t4_chan_ch0", 32'(out_chan), 32'h0);
    chk("t4_data_ch0", 32'(out_data), 32'hE0);

    // Random traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        in_valid[k] = ($urandom_range(0, 9) < 6);
        set_ch(k, 8'($urandom), ($urandom_range(0, 9) < 3));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) sel = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 499) != 0);
    end
    @(posedge clk); #1; rst_n = 1'b1; in_valid = 4'h0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel streaming multiplexer with a valid/ready handshake on every input and on the output. It selects one input channel by round-robin arbitration or by an external select, holds that channel until its packet completes, and registers the result. It is the sequential successor to the combinational 4:1 mux and is used wherever several producers share one downstream consumer.

## Interface
- N, default 4: number of input channels, 2..16.
- W, default 8: data width per channel.
- CW, default $clog2(N): channel index width, minimum 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  N*W  channel k occupies bits [k*W +: W].
- in_valid  in  N  per-channel valid.
- in_last  in  N  per-channel end-of-packet marker.
- in_ready  out  N  per-channel ready; at most one bit is high in any cycle.
- mode  in  1  0 = round-robin, 1 = fixed select.
- sel  in  CW  channel used when mode = 1; values >= N select nothing.
- out_data  out  W  registered data.
- out_valid  out  1  registered valid.
- out_last  out  1  registered last.
- out_chan  out  CW  index of the channel that produced out_data.
- out_ready  in  1  downstream ready.

## Operation
- Transfer rules: an input beat transfers when in_valid[k] & in_ready[k]. An output beat transfers when out_valid & out_ready.
- Output stage: a single register. space = !out_valid | out_ready.
- States:
  - IDLE: no channel locked.
  - LOCKED: grant register g holds one channel.
- Candidate in IDLE:
  - mode = 0: the first k with in_valid[k] set, scanning ptr, ptr+1, … modulo N.
  - mode = 1: k = sel, only if sel < N and in_valid[sel] is set.
  - mode and sel are sampled only in IDLE. Changes while LOCKED are ignored.
- Ready generation:
  - IDLE: in_ready[candidate] = space. All other in_ready bits are 0.
  - LOCKED: in_ready[g] = space. All other in_ready bits are 0.
- On an input transfer from channel c:
  - Load out_data, out_last and out_chan with the beat from c, and set out_valid = 1.
  - If in_last[c] = 0: go to LOCKED with g = c.
  - If in_last[c] = 1: stay in or return to IDLE, and set ptr = (c == N-1) ? 0 : c+1. The pointer update applies in both modes.
- Output hold: out_valid clears on an output transfer with no simultaneous input transfer. Otherwise the output registers hold.
- Single-beat packet (last on the first beat): no LOCKED cycle.
- LOCKED with in_valid[g] = 0: the block waits. Other channels are never granted mid-packet.
- Reset values: out_valid = 0, out_data = 0, out_last = 0, out_chan = 0, state = IDLE, ptr = 0, g = 0.
  - in_ready is all-zero during reset.
  - Reset mid-packet abandons the packet. The channel is re-arbitrated from ptr = 0 after reset release.

## Timing
- Latency: one cycle from an input transfer to out_valid/out_data at the next edge.
- Throughput: one beat per cycle when out_ready is held at 1. No bubble at a packet boundary, because the next channel may transfer in the cycle after the last beat.
- Backpressure: in_ready is combinational from out_ready, out_valid, state, ptr, mode, sel and in_valid. No combinational path exists from in_* to out_*.
- Simultaneous output drain and input load in one cycle: out_valid stays 1 and the new data is loaded.
- Output stability: while out_valid = 1 and out_ready = 0, out_data, out_last and out_chan are stable.

## Test plan
- Reset, then all four in_valid = 1 with single-beat packets (last = 1), mode = 0, out_ready = 1: out_chan sequence 0,1,2,3,0, one beat per cycle starting one cycle after the first transfer.
- Channel 2 sends a 3-beat packet (data 0xA1, 0xA2, 0xA3, last on the third beat) while channels 0 and 1 are also valid, mode = 0, ptr = 2: outputs A1, A2, A3 with out_chan = 2, then channel 0. in_ready[0] and in_ready[1] stay 0 throughout.
- out_ready = 0 for 3 cycles mid-packet: out_data is held and in_ready[g] = 0 for those cycles. The beat following the stall is neither lost nor duplicated.
- mode = 1, sel = 1, channels 0 and 1 valid: only channel 1 is served. Change sel to 3 mid-packet: the current packet finishes on channel 1, and the next packet comes from channel 3.
- mode = 1, sel = 3 with N = 3: no in_ready is asserted and out_valid stays 0.
- Assert rst_n = 0 during the second beat of a packet: out_valid = 0 and in_ready = 0 immediately. After release, a valid channel 0 is granted first.
